pop_sequencer: RTL

Parametrised, run-time programmable successor to the fixed-timing POP pulse generator. It produces NCH timing channels (pump, probe, MW, sample, ...), each with NWIN programmable high windows inside a common programmable period. It supports continuous or N-shot operation and glitch-free reprogramming at cycle boundaries. It sits between the host register bank and the laser/MW/ADC drivers, clocked from the 2.5 MHz timing clock.

---
 rtl/pop_sequencer_if.sv | 29 ++
 rtl/pop_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pop_sequencer_if.sv
// Host-side bus of the POP sequencer: sequence control pulses, the
// configuration write port and the timing outputs. The host/bench drives
// the master side, the sequencer implements the slave side.
interface pop_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 4,
  parameter int AWIDTH = 8
);
  logic              start;
  logic              stop;
  logic              cfg_we;
  logic [AWIDTH-1:0] cfg_addr;
  logic [WIDTH-1:0]  cfg_data;
  logic [NCH-1:0]    ch_out;
  logic [WIDTH-1:0]  cnt;
  logic              busy;
  logic              cycle_done;
  logic              cfg_err;

  modport master (
    output start, stop, cfg_we, cfg_addr, cfg_data,
    input  ch_out, cnt, busy, cycle_done, cfg_err
  );

  modport slave (
    input  start, stop, cfg_we, cfg_addr, cfg_data,
    output ch_out, cnt, busy, cycle_done, cfg_err
  );
endinterface

// File: rtl/pop_sequencer.sv
// Programmable POP timing sequencer: NCH channels, each with NWIN high
// windows inside a common period, continuous or N-shot operation.
// Configuration is written into pending registers and copied to the active
// set only on an accepted start or a period wrap, so reprogramming never
// glitches a period in progress.
// Optional feature macro POP_SEQ_EXT_TRIG_EN: adds ext_trig input and an
// ARM state; every period then waits for a rising edge of ext_trig.
module pop_sequencer #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 4,
  parameter int NWIN   = 2,
  parameter int RWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic clock_2_5M,
  input  logic reset,
`ifdef POP_SEQ_EXT_TRIG_EN
  input  logic ext_trig,
`endif
  pop_sequencer_if.slave bus
);

  localparam int NEDGE       = NCH * NWIN;
  localparam int ADDR_PERIOD = NEDGE * 2;
  localparam int ADDR_REPEAT = NEDGE * 2 + 1;

`ifdef POP_SEQ_EXT_TRIG_EN
  typedef enum logic [1:0] {IDLE, RUN, ARM} state_t;
  localparam state_t PERIOD_ENTRY = ARM;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
  localparam state_t PERIOD_ENTRY = RUN;
`endif

  state_t state, state_n;

  logic [WIDTH-1:0]  cnt, cnt_n;
  logic [RWIDTH-1:0] remaining, rem_n;
  logic              stop_req, stop_req_n;
  logic              cfg_err, err_n;
  logic              load_act;
  logic              last;
  logic [NCH-1:0]    ch_q, ch_n;

  logic [NEDGE-1:0][WIDTH-1:0] pend_start, pend_stop;
  logic [NEDGE-1:0][WIDTH-1:0] act_start, act_stop;
  logic [NEDGE-1:0][WIDTH-1:0] act_start_n, act_stop_n;
  logic [WIDTH-1:0]            pend_period, act_period;
  logic [RWIDTH-1:0]           pend_repeat, act_repeat;

`ifdef POP_SEQ_EXT_TRIG_EN
  logic [2:0] trig_sync;
  logic       trig_rise;

  // Two-flop synchroniser for the asynchronous trigger plus an edge-history flop
  always_ff @(posedge clock_2_5M) begin
    if (reset) trig_sync <= '0;
    else       trig_sync <= {trig_sync[1:0], ext_trig};
  end

  assign trig_rise = trig_sync[1] & ~trig_sync[2];
`endif

  // Host writes always land in the pending set; unknown addresses are dropped
  always_ff @(posedge clock_2_5M) begin
    if (reset) begin
      pend_start  <= '0;
      pend_stop   <= '0;
      pend_period <= '0;
      pend_repeat <= '0;
    end else if (bus.cfg_we) begin
      for (int i = 0; i < NEDGE; i++) begin
        if (bus.cfg_addr == AWIDTH'(2 * i))     pend_start[i] <= bus.cfg_data;
        if (bus.cfg_addr == AWIDTH'(2 * i + 1)) pend_stop[i]  <= bus.cfg_data;
      end
      if (bus.cfg_addr == AWIDTH'(ADDR_PERIOD)) pend_period <= bus.cfg_data;
      if (bus.cfg_addr == AWIDTH'(ADDR_REPEAT)) pend_repeat <= RWIDTH'(bus.cfg_data);
    end
  end

  // Active set is refreshed from pending only at sequence start or period wrap
  always_ff @(posedge clock_2_5M) begin
    if (reset) begin
      act_start  <= '0;
      act_stop   <= '0;
      act_period <= '0;
      act_repeat <= '0;
    end else if (load_act) begin
      act_start  <= pend_start;
      act_stop   <= pend_stop;
      act_period <= pend_period;
      act_repeat <= pend_repeat;
    end
  end

  // Last count of the period; widened so a zero period cannot run the counter away
  assign last = ((WIDTH+1)'(cnt) + (WIDTH+1)'(1)) >= (WIDTH+1)'(act_period);

  // Sequencing: next state, counter, repeat bookkeeping and stop latching
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = remaining;
    stop_req_n = stop_req;
    err_n      = cfg_err;
    load_act   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n      = '0;
        stop_req_n = 1'b0;
        if (bus.start) begin
          if (pend_period < WIDTH'(2)) begin
            err_n = 1'b1;
          end else begin
            err_n    = 1'b0;
            load_act = 1'b1;
            rem_n    = pend_repeat;
            state_n  = PERIOD_ENTRY;
          end
        end
      end
      RUN: begin
        if (bus.stop) stop_req_n = 1'b1;
        if (last) begin
          cnt_n = '0;
          if (stop_req || bus.stop ||
              (act_repeat != '0 && remaining == RWIDTH'(1))) begin
            state_n    = IDLE;
            stop_req_n = 1'b0;
          end else begin
            load_act = 1'b1;
            if (act_repeat != '0) rem_n = remaining - RWIDTH'(1);
            state_n = PERIOD_ENTRY;
          end
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end
`ifdef POP_SEQ_EXT_TRIG_EN
      ARM: begin
        cnt_n = '0;
        if (bus.stop) begin
          state_n    = IDLE;
          stop_req_n = 1'b0;
        end else if (trig_rise) begin
          state_n = RUN;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Windows are evaluated on the upcoming count and active set so ch_out lines up with cnt
  always_comb begin
    act_start_n = load_act ? pend_start : act_start;
    act_stop_n  = load_act ? pend_stop  : act_stop;
    ch_n        = '0;
    if (state_n == RUN) begin
      for (int c = 0; c < NCH; c++) begin
        for (int w = 0; w < NWIN; w++) begin
          if (act_start_n[c*NWIN+w] <= cnt_n && cnt_n < act_stop_n[c*NWIN+w])
            ch_n[c] = 1'b1;
        end
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clock_2_5M) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
      stop_req  <= 1'b0;
      cfg_err   <= 1'b0;
      ch_q      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      remaining <= rem_n;
      stop_req  <= stop_req_n;
      cfg_err   <= err_n;
      ch_q      <= ch_n;
    end
  end

  assign bus.ch_out     = ch_q;
  assign bus.cnt        = cnt;
  assign bus.busy       = (state != IDLE);
  assign bus.cycle_done = (state == RUN) && last;
  assign bus.cfg_err    = cfg_err;

endmodule
